// File: rtl/shifter_pkg.sv
// shifter_pkg: opcodes, sequencer states and step size shared by the shift sequencer and its shifter.
// Revision 1.0
`default_nettype none

package shifter_pkg;

  localparam logic [3:0] OP_LOAD = 4'b0100;
  localparam logic [3:0] OP_HOLD = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b1000;
  localparam logic [3:0] OP_ROR  = 4'b1001;
  localparam logic [3:0] OP_LSL  = 4'b0010;
  localparam logic [3:0] OP_ASL  = 4'b1010;
  localparam logic [3:0] OP_ASR  = 4'b1011;

  localparam int MAX_STEP = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    CAPT  = 2'd3
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_ROL) || (op == OP_ROR) || (op == OP_LSL) ||
           (op == OP_ASL) || (op == OP_ASR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shifter.sv
// barrel_shifter: registered N-bit shifter moving 0..3 bits per clock; LOAD/HOLD manage the register.
// Revision 1.0
`default_nettype none

module barrel_shifter
  import shifter_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] datain,
  input  logic [3:0]   op,
  input  logic [1:0]   s,
  output logic [N-1:0] dataout
);

  logic [N-1:0]   data_q, data_d;
  logic [2*N-1:0] rol_w, ror_w;

  // Rotations take the matching half of the doubled word.
  assign rol_w = {data_q, data_q} << s;
  assign ror_w = {data_q, data_q} >> s;

  always_comb begin
    data_d = data_q;
    case (op)
      OP_LOAD:         data_d = datain;
      OP_ROL:          data_d = rol_w[2*N-1:N];
      OP_ROR:          data_d = ror_w[N-1:0];
      OP_LSL, OP_ASL:  data_d = data_q << s;
      OP_ASR:          data_d = $signed(data_q) >>> s;
      default:         data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign dataout = data_q;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant; on contention the side not granted last wins.
// Revision 1.0
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       gnt_idx_o,
  output logic       gnt_valid_o
);

  always_comb begin
    gnt_valid_o = |req_valid_i;
    gnt_idx_o   = 1'b0;
    if (&req_valid_i) gnt_idx_o = ~last_grant_i;
    else              gnt_idx_o = req_valid_i[1];
  end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// shift_sequencer: shares one barrel_shifter between two requesters, splitting large amounts into 3-bit steps.
// Revision 1.0
`default_nettype none

module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int N  = 5,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_data,
  input  logic [3:0]    req0_op,
  input  logic [AW-1:0] req0_amt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_data,
  input  logic [3:0]    req1_op,
  input  logic [AW-1:0] req1_amt,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic [N-1:0]  result,
  output logic [N-1:0]  sh_datain,
  output logic [3:0]    sh_op,
  output logic [1:0]    sh_s,
  input  logic [N-1:0]  sh_dataout
);

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] amt_q, amt_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          id_q, id_d;
  logic          last_grant_q, last_grant_d;
  logic [N-1:0]  result_q, result_d;
  logic          done_q, done_d;
  logic          done_id_q, done_id_d;

  logic          gnt_idx, gnt_valid, accept;
  logic [1:0]    step;

  rr_arbiter2 u_arb (
    .req_valid_i  ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  // Readys are qualified by rst_n so nothing is accepted while reset is held.
  assign accept     = (state_q == IDLE) && gnt_valid && rst_n;
  assign req0_ready = accept && !gnt_idx;
  assign req1_ready = accept &&  gnt_idx;

  assign step = (rem_q > AW'(MAX_STEP)) ? 2'(MAX_STEP) : rem_q[1:0];

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    op_d         = op_q;
    amt_d        = amt_q;
    rem_d        = rem_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    sh_op        = OP_HOLD;
    sh_s         = 2'd0;
    sh_datain    = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d       = gnt_idx ? req1_data : req0_data;
          op_d         = gnt_idx ? req1_op   : req0_op;
          amt_d        = gnt_idx ? req1_amt  : req0_amt;
          id_d         = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        sh_op     = OP_LOAD;
        sh_datain = data_q;
        rem_d     = is_shift_op(op_q) ? amt_q : '0;
        state_d   = (rem_d != '0) ? SHIFT : CAPT;
      end
      SHIFT: begin
        sh_op = op_q;
        sh_s  = step;
        rem_d = rem_q - AW'(step);
        if (rem_d == '0) state_d = CAPT;
      end
      CAPT: begin
        result_d  = sh_dataout;
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      op_q         <= OP_HOLD;
      amt_q        <= '0;
      rem_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      op_q         <= op_d;
      amt_q        <= amt_d;
      rem_q        <= rem_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table vectors, arbitration/reset sequences and random commands against a reference model.
// Revision 1.0
`default_nettype none

module tb_shift_sequencer;
  import shifter_pkg::*;

  localparam int N  = 5;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [N-1:0]  req0_data = '0, req1_data = '0;
  logic [3:0]    req0_op = '0, req1_op = '0;
  logic [AW-1:0] req0_amt = '0, req1_amt = '0;
  logic          busy, done, done_id;
  logic [N-1:0]  result, sh_datain, sh_dataout;
  logic [3:0]    sh_op;
  logic [1:0]    sh_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_op(req0_op), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_op(req1_op), .req1_amt(req1_amt),
    .busy(busy), .done(done), .done_id(done_id), .result(result),
    .sh_datain(sh_datain), .sh_op(sh_op), .sh_s(sh_s), .sh_dataout(sh_dataout)
  );

  barrel_shifter #(.N(N)) u_shifter (
    .clk(clk), .rst_n(rst_n), .datain(sh_datain), .op(sh_op), .s(sh_s), .dataout(sh_dataout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whole-amount result computed directly, not step by step.
  function automatic logic [N-1:0] model_result(input logic [N-1:0] d, input logic [3:0] op,
                                                input int amt);
    logic [2*N-1:0]      dbl;
    logic signed [N-1:0] sd;
    int                  r;
    dbl = {d, d};
    sd  = d;
    r   = amt % N;
    case (op)
      OP_ROL:         begin dbl = dbl << r; return dbl[2*N-1:N]; end
      OP_ROR:         begin dbl = dbl >> r; return dbl[N-1:0]; end
      OP_LSL, OP_ASL: return (amt >= N) ? '0 : N'(d << amt);
      OP_ASR:         return (amt >= N) ? {N{d[N-1]}} : N'(sd >>> amt);
      default:        return d;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] op, input int amt);
    int k;
    k = is_shift_op(op) ? (amt + MAX_STEP - 1) / MAX_STEP : 0;
    return k + 2;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input logic id, input logic [N-1:0] d, input logic [3:0] op,
                         input logic [AW-1:0] amt);
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_op = op; req1_amt = amt;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_op = op; req0_amt = amt;
    end
  endtask

  // Waits for done with a cycle bound, starting at the negedge after the accept edge.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: done not seen within 30 cycles", tag);
    end
  endtask

  task automatic run_cmd(input string tag, input logic id, input logic [N-1:0] d,
                         input logic [3:0] op, input logic [AW-1:0] amt,
                         input logic [N-1:0] exp_res);
    int cyc;
    int w;
    set_req(id, d, op, amt);
    #1;
    w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({tag, " ready"}, id ? req1_ready : req0_ready, 1'b1);
    check({tag, " other ready"}, id ? req0_ready : req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    check({tag, " busy"}, busy, 1'b1);
    wait_done(tag, cyc);
    if (cyc != 0) begin
      check({tag, " latency"}, cyc, model_latency(op, int'(amt)));
      check({tag, " result"}, result, exp_res);
      check({tag, " done_id"}, done_id, id);
      @(negedge clk);
      check({tag, " done pulse"}, done, 1'b0);
      check({tag, " result held"}, result, exp_res);
    end
  endtask

  typedef struct {
    logic          id;
    logic [N-1:0]  data;
    logic [3:0]    op;
    logic [AW-1:0] amt;
    logic [N-1:0]  exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [3:0] ops[9];
    int         cyc;
    logic [N-1:0] d;
    logic [3:0]   op;
    logic [AW-1:0] amt;
    logic          id;

    vecs[0] = '{1'b0, 5'b01010, OP_ROL,  4'd2,  5'b01001};
    vecs[1] = '{1'b1, 5'b10010, OP_ROR,  4'd7,  5'b10100};
    vecs[2] = '{1'b0, 5'b10010, OP_ASR,  4'd4,  5'b11111};
    vecs[3] = '{1'b0, 5'b00111, OP_LSL,  4'd6,  5'b00000};
    vecs[4] = '{1'b1, 5'b10101, 4'b0111, 4'd5,  5'b10101};
    vecs[5] = '{1'b0, 5'b01101, OP_ASL,  4'd1,  5'b11010};
    vecs[6] = '{1'b1, 5'b10110, OP_ROL,  4'd0,  5'b10110};
    vecs[7] = '{1'b0, 5'b01100, OP_ASR,  4'd15, 5'b00000};
    vecs[8] = '{1'b1, 5'b10001, OP_ROL,  4'd5,  5'b10001};

    // Reset values, with both requesters valid while reset is held.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst ready0", req0_ready, 1'b0);
    check("rst ready1", req1_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst done_id", done_id, 1'b0);
    check("rst result", result, '0);
    check("rst sh_op", sh_op, OP_HOLD);
    check("rst sh_s", sh_s, 2'd0);
    check("rst sh_datain", sh_datain, '0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].id, vecs[i].data, vecs[i].op, vecs[i].amt,
              vecs[i].exp);

    // Contention straight after reset: req0 first, req1's ready low until req0's done cycle.
    do_reset();
    set_req(1'b0, 5'b00011, OP_ROL, 4'd1);
    set_req(1'b1, 5'b11000, OP_ASR, 4'd2);
    #1;
    check("arb ready0", req0_ready, 1'b1);
    check("arb ready1", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      if (done) begin
        cyc = i;
        break;
      end
      check("arb loser ready", req1_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    if (cyc == 0) begin
      checks++; errors++;
      $display("FAIL arb first done timeout");
    end
    check("arb first id", done_id, 1'b0);
    check("arb first result", result, 5'b00110);
    check("arb ready1 in done cycle", req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_done("arb second", cyc);
    check("arb second id", done_id, 1'b1);
    check("arb second result", result, 5'b11110);

    // Reset asserted while SHIFT steps are in progress.
    @(negedge clk);
    set_req(1'b0, 5'b10110, OP_ROR, 4'd15);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid busy before reset", busy, 1'b1);
    check("mid sh_op shifting", sh_op, OP_ROR);
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid rst busy", busy, 1'b0);
    check("mid rst done", done, 1'b0);
    check("mid rst ready0", req0_ready, 1'b0);
    check("mid rst sh_op", sh_op, OP_HOLD);
    check("mid rst sh_s", sh_s, 2'd0);
    check("mid rst sh_datain", sh_datain, '0);
    check("mid rst result", result, '0);
    check("mid rst done_id", done_id, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid rst no done", done, 1'b0);
      if (i == 2) begin
        req0_valid = 1'b0;
        rst_n = 1'b1;
      end
    end
    run_cmd("after rst", 1'b1, 5'b01011, OP_ROR, 4'd8,
            model_result(5'b01011, OP_ROR, 8));

    // Random commands against the reference model.
    ops = '{OP_ROL, OP_ROR, OP_LSL, OP_ASL, OP_ASR, OP_LOAD, OP_HOLD, 4'b0111, 4'b0000};
    for (int t = 0; t < 40; t++) begin
      id  = 1'($urandom_range(0, 1));
      d   = N'($urandom);
      op  = ops[$urandom_range(0, 8)];
      amt = AW'($urandom);
      run_cmd($sformatf("rand%0d", t), id, d, op, amt, model_result(d, op, int'(amt)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
